// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter (core vs DMA/debug) with lock-based ownership,
// a bounded hold count for fairness, and registered one-cycle read return per port.

module mem_arbiter_rd (
  input  logic        clk,
  input  logic        reset,
  input  logic        gnt,
  input  logic        we,
  input  logic [31:0] mem_rdata,
  output logic        rvalid,
  output logic [31:0] rdata
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= gnt & ~we;
      if (gnt && !we) rdata <= mem_rdata;
    end
  end
endmodule

module mem_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        r0_req,
  input  logic        r1_req,
  input  logic        r0_we,
  input  logic        r1_we,
  input  logic [31:0] r0_adr,
  input  logic [31:0] r1_adr,
  input  logic [31:0] r0_wdata,
  input  logic [31:0] r1_wdata,
  input  logic        r0_lock,
  input  logic        r1_lock,
  output logic        r0_gnt,
  output logic        r1_gnt,
  output logic        r0_rvalid,
  output logic        r1_rvalid,
  output logic [31:0] r0_rdata,
  output logic [31:0] r1_rdata,
  output logic        MemWrite,
  output logic [31:0] Adr,
  output logic [31:0] WriteData,
  input  logic [31:0] ReadData
);
  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);
  localparam logic [8:0] HOLD_LIM = 9'(MAX_HOLD);

  state_t           state;
  logic             last;
  logic [7:0]       hold_cnt;
  logic [8:0]       hold_inc;
  logic             own_req, own_lock, oth_req, oth_id;
  state_t           oth_state;
  logic [1:0]       gnt, we, rvalid;
  logic [1:0][31:0] rdata;

  assign r0_gnt = (state == OWN0) && r0_req;
  assign r1_gnt = (state == OWN1) && r1_req;

  // Owner-relative views so OWN0/OWN1 share one transition body
  assign own_req   = (state == OWN1) ? r1_req  : r0_req;
  assign own_lock  = (state == OWN1) ? r1_lock : r0_lock;
  assign oth_req   = (state == OWN1) ? r0_req  : r1_req;
  assign oth_id    = (state == OWN0);
  assign oth_state = (state == OWN0) ? OWN1 : OWN0;
  assign hold_inc  = {1'b0, hold_cnt} + 9'd1;

  always_comb begin
    MemWrite  = 1'b0;
    Adr       = '0;
    WriteData = '0;
    if (r0_gnt) begin
      MemWrite  = r0_we;
      Adr       = r0_adr;
      WriteData = r0_wdata;
    end else if (r1_gnt) begin
      MemWrite  = r1_we;
      Adr       = r1_adr;
      WriteData = r1_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      last     <= 1'b1;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          // On a tie the requester that did not own last wins
          if (r0_req && (!r1_req || last)) begin
            state    <= OWN0;
            last     <= 1'b0;
            hold_cnt <= '0;
          end else if (r1_req) begin
            state    <= OWN1;
            last     <= 1'b1;
            hold_cnt <= '0;
          end
        end
        OWN0, OWN1: begin
          if (oth_req && (!own_req || !own_lock || hold_inc >= HOLD_LIM)) begin
            state    <= oth_state;
            last     <= oth_id;
            hold_cnt <= '0;
          end else if (!own_req) begin
            state <= IDLE;
          end else if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_inc[7:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign gnt = {r1_gnt, r0_gnt};
  assign we  = {r1_we, r0_we};

  // Read return lives per port so a handoff never steals the previous owner's rvalid
  for (genvar p = 0; p < 2; p++) begin : g_rd
    mem_arbiter_rd u_rd (
      .clk       (clk),
      .reset     (reset),
      .gnt       (gnt[p]),
      .we        (we[p]),
      .mem_rdata (ReadData),
      .rvalid    (rvalid[p]),
      .rdata     (rdata[p])
    );
  end

  assign r0_rvalid = rvalid[0];
  assign r1_rvalid = rvalid[1];
  assign r0_rdata  = rdata[0];
  assign r1_rdata  = rdata[1];
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a cycle-level ownership model.

module tb_mem_arbiter;
  localparam int MAX_HOLD = 8;

  logic        clk = 1'b0, reset = 1'b0;
  logic        r0_req, r1_req, r0_we, r1_we, r0_lock, r1_lock;
  logic [31:0] r0_adr, r1_adr, r0_wdata, r1_wdata, ReadData;
  logic        r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, MemWrite;
  logic [31:0] r0_rdata, r1_rdata, Adr, WriteData;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r1_req(r1_req), .r0_we(r0_we), .r1_we(r1_we),
    .r0_adr(r0_adr), .r1_adr(r1_adr), .r0_wdata(r0_wdata), .r1_wdata(r1_wdata),
    .r0_lock(r0_lock), .r1_lock(r1_lock),
    .r0_gnt(r0_gnt), .r1_gnt(r1_gnt), .r0_rvalid(r0_rvalid), .r1_rvalid(r1_rvalid),
    .r0_rdata(r0_rdata), .r1_rdata(r1_rdata),
    .MemWrite(MemWrite), .Adr(Adr), .WriteData(WriteData), .ReadData(ReadData)
  );

  int n_chk = 0, n_err = 0;

  // Model: owner is -1 when idle, else the requester index holding the memory
  int          own, lastw, held;
  logic [1:0]  m_rv;
  logic [31:0] m_rd [2];
  int          waitc [2];
  int          rd_gnts, rvs;
  logic        sg0, sg1, srv0, srv1, smw;
  logic [31:0] srd0, sadr, swd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    own = -1; lastw = 1; held = 0; m_rv = '0;
    m_rd[0] = '0; m_rd[1] = '0;
    waitc[0] = 0; waitc[1] = 0; rd_gnts = 0; rvs = 0;
  endtask

  task automatic idle_inputs();
    r0_req = 0; r1_req = 0; r0_we = 0; r1_we = 0; r0_lock = 0; r1_lock = 0;
    r0_adr = '0; r1_adr = '0; r0_wdata = '0; r1_wdata = '0; ReadData = '0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"}, {r1_gnt, r0_gnt}, 0);
    chk({tag, "_rvalid"}, {r1_rvalid, r0_rvalid}, 0);
    chk({tag, "_rdata0"}, r0_rdata, 0);
    chk({tag, "_rdata1"}, r1_rdata, 0);
    chk({tag, "_memwrite"}, MemWrite, 0);
    chk({tag, "_adr"}, Adr, 0);
    chk({tag, "_wdata"}, WriteData, 0);
  endtask

  task automatic do_reset();
    reset = 0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk_zero("rst");
    model_reset();
    reset = 1;
  endtask

  // Called at posedge+1 with inputs already driven; returns at the next posedge+1
  task automatic step();
    logic [1:0]  rq, wq, lk, eg;
    logic [31:0] ea, ed;
    logic        ew;
    int          o, t;
    #3;
    rq = {r1_req, r0_req}; wq = {r1_we, r0_we}; lk = {r1_lock, r0_lock};
    eg[0] = (own == 0) && rq[0];
    eg[1] = (own == 1) && rq[1];
    ea = eg[0] ? r0_adr   : eg[1] ? r1_adr   : 32'h0;
    ed = eg[0] ? r0_wdata : eg[1] ? r1_wdata : 32'h0;
    ew = eg[0] ? r0_we    : eg[1] ? r1_we    : 1'b0;
    chk("gnt0", r0_gnt, eg[0]);
    chk("gnt1", r1_gnt, eg[1]);
    chk("onehot", r0_gnt & r1_gnt, 0);
    chk("adr", Adr, ea);
    chk("memwrite", MemWrite, ew);
    chk("wdata", WriteData, ed);
    chk("rvalid0", r0_rvalid, m_rv[0]);
    chk("rvalid1", r1_rvalid, m_rv[1]);
    chk("rdata0", r0_rdata, m_rd[0]);
    chk("rdata1", r1_rdata, m_rd[1]);
    sg0 = r0_gnt; sg1 = r1_gnt; srv0 = r0_rvalid; srv1 = r1_rvalid;
    srd0 = r0_rdata; smw = MemWrite; sadr = Adr; swd = WriteData;
    for (int i = 0; i < 2; i++) begin
      if (rq[i] && !(i == 0 ? r0_gnt : r1_gnt)) waitc[i]++;
      else waitc[i] = 0;
      if (rq[i]) chk("wait_bound", waitc[i] > MAX_HOLD + 1, 0);
    end
    rd_gnts += int'(r0_gnt && !r0_we) + int'(r1_gnt && !r1_we);
    rvs     += int'(r0_rvalid) + int'(r1_rvalid);

    // Advance model for the coming edge
    m_rv = eg & ~wq;
    if (m_rv[0]) m_rd[0] = ReadData;
    if (m_rv[1]) m_rd[1] = ReadData;
    if (own < 0) begin
      if (rq == 2'b11)  own = 1 - lastw;
      else if (rq[0])   own = 0;
      else if (rq[1])   own = 1;
      if (own >= 0) begin lastw = own; held = 0; end
    end else begin
      o = own; t = 1 - own;
      if (!rq[o]) begin
        own = rq[t] ? t : -1;
        if (own >= 0) begin lastw = own; held = 0; end
      end else if (rq[t] && (!lk[o] || held + 1 >= MAX_HOLD)) begin
        own = t; lastw = t; held = 0;
      end else begin
        held = (held + 1 > MAX_HOLD) ? MAX_HOLD : held + 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt, first1;
    idle_inputs();

    // Simple read from idle: grant on the second edge, data one cycle later
    do_reset();
    r0_req = 1; r0_adr = 32'h100; ReadData = 32'hDEADBEEF;
    step(); chk("first_gnt_lat", sg0, 0);
    step(); chk("rd_gnt", sg0, 1); chk("rd_adr", sadr, 32'h100);
    r0_req = 0;
    step(); chk("rd_rvalid", srv0, 1); chk("rd_rdata", srd0, 32'hDEADBEEF);
    step(); chk("rd_rvalid_pulse", srv0, 0);

    // Both requesting without lock: r0 first, then strict alternation
    do_reset();
    r0_req = 1; r1_req = 1;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("alt_g0", sg0, (k >= 2) && (k % 2 == 0));
      chk("alt_g1", sg1, (k >= 3) && (k % 2 == 1));
    end

    // Locked r0 holds for exactly MAX_HOLD grants while r1 waits
    do_reset();
    r0_req = 1; r1_req = 1; r0_lock = 1;
    cnt = 0; first1 = -1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (sg1 && first1 < 0) first1 = k;
      if (sg0 && first1 < 0) cnt++;
    end
    chk("lock_hold", cnt, MAX_HOLD);
    chk("lock_handoff", first1, MAX_HOLD + 2);

    // r1 write
    do_reset();
    r1_req = 1; r1_we = 1; r1_adr = 32'h40; r1_wdata = 32'h12345678;
    step();
    step(); chk("wr_gnt", sg1, 1); chk("wr_memwrite", smw, 1);
    chk("wr_adr", sadr, 32'h40); chk("wr_data", swd, 32'h12345678);
    r1_req = 0;
    step(); chk("wr_no_rvalid", srv1, 0);

    // Reset asserted right after a read grant drops the pending rvalid
    do_reset();
    r0_req = 1; r0_adr = 32'h200; ReadData = 32'hCAFEF00D;
    step();
    #3; chk("arst_gnt", r0_gnt, 1);
    @(posedge clk); reset = 0;
    repeat (3) begin #3; chk_zero("arst"); @(posedge clk); end
    #1; model_reset(); reset = 1;
    step(); chk("rearb_idle", sg0, 0);
    step(); chk("rearb_gnt", sg0, 1);

    // Random traffic against the model
    do_reset();
    for (int k = 0; k < 10000; k++) begin
      r0_req = $urandom_range(0, 3) != 0; r1_req = $urandom_range(0, 3) != 0;
      r0_we = $urandom_range(0, 1) != 0;  r1_we = $urandom_range(0, 1) != 0;
      r0_lock = $urandom_range(0, 2) != 0; r1_lock = $urandom_range(0, 2) != 0;
      r0_adr = $urandom; r1_adr = $urandom; r0_wdata = $urandom; r1_wdata = $urandom;
      ReadData = $urandom;
      step();
    end
    idle_inputs();
    step(); step();
    chk("rvalid_count", rvs, rd_gnts);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
